// File: rtl/mod_mul_p.sv
// rtl/mod_mul_p.sv - bit-serial MSB-first a*b mod p over the SM2 prime
// Define MOD_MUL_P_RADIX4_EN to retire two multiplier bits per ITER cycle.
module mod_mul_p (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] a,
  input  logic [255:0] b,
  output logic [255:0] c,
  output logic         done,
  output logic         busy
);

  localparam logic [255:0] P256 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [256:0] P = {1'b0, P256};

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_LOAD = 4'b0010;
  localparam logic [3:0] S_ITER = 4'b0100;
  localparam logic [3:0] S_FIN  = 4'b1000;

`ifdef MOD_MUL_P_RADIX4_EN
  localparam logic [7:0] LAST_CNT = 8'd127;
`else
  localparam logic [7:0] LAST_CNT = 8'd255;
`endif

  logic [3:0]   state;
  logic [255:0] reg_a;
  logic [255:0] reg_b;
  logic [256:0] acc;
  logic [7:0]   cnt;
  logic [255:0] red_a;
  logic [255:0] red_b;
  logic [256:0] step1;
  logic [256:0] step_out;

  // Inputs can reach 2^256-1; since 2^256 < 2p one conditional subtract lands them in [0, p).
  function automatic logic [255:0] reduce(input logic [255:0] x);
    if ({1'b0, x} >= P) return x - P256;
    return x;
  endfunction

  // One radix-2 step: acc < p and add < p keep every intermediate below 2^257.
  function automatic logic [256:0] mod_step(input logic [256:0] acc_in,
                                            input logic [255:0] add,
                                            input logic         bit_in);
    logic [256:0] t;
    logic [256:0] u;
    t = acc_in << 1;
    if (t >= P) t = t - P;
    u = t;
    if (bit_in) begin
      u = t + {1'b0, add};
      if (u >= P) u = u - P;
    end
    return u;
  endfunction

  always_comb begin
    red_a = reduce(reg_a);
    red_b = reduce(reg_b);
    step1 = mod_step(acc, reg_a, reg_b[255]);
`ifdef MOD_MUL_P_RADIX4_EN
    step_out = mod_step(step1, reg_a, reg_b[254]);
`else
    step_out = step1;
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      reg_a <= '0;
      reg_b <= '0;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            reg_a <= a;
            reg_b <= b;
            acc   <= '0;
            cnt   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          reg_a <= red_a;
          reg_b <= red_b;
          state <= S_ITER;
        end
        S_ITER: begin
          acc <= step_out;
          cnt <= cnt + 8'd1;
`ifdef MOD_MUL_P_RADIX4_EN
          reg_b <= reg_b << 2;
`else
          reg_b <= reg_b << 1;
`endif
          // Result is published on the final step so c is already valid while done is high.
          if (cnt == LAST_CNT) begin
            c     <= step_out[255:0];
            done  <= 1'b1;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mul_p.sv
// tb/tb_mod_mul_p.sv - directed and random checks of mod_mul_p
module tb_mod_mul_p;

  localparam logic [255:0] P256 =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [255:0] ONES = {256{1'b1}};
  localparam logic [255:0] R256M1 =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000000;
  localparam logic [255:0] R256 =
    256'h00000001_00000000_00000000_00000000_00000000_FFFFFFFF_00000000_00000001;
`ifdef MOD_MUL_P_RADIX4_EN
  localparam int LAT = 130;
`else
  localparam int LAT = 258;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] c;
  logic         done;
  logic         busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] c;
  } vec_t;

  vec_t vecs[9];

  mod_mul_p dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check_v(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_mul(input logic [255:0] x, input logic [255:0] y);
    logic [511:0] prod;
    prod = {256'b0, x} * {256'b0, y};
    return 256'(prod % {256'b0, P256});
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Drives start for exactly one edge; returns just after that edge with operands scrambled.
  task automatic launch(input logic [255:0] x, input logic [255:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = rand256();
    b = rand256();
  endtask

  task automatic watch(input int ncyc, output int ndone, output int first, output logic [255:0] cap);
    ndone = 0;
    first = 0;
    cap = '0;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first == 0) begin
          first = n;
          cap = c;
        end
      end
    end
  endtask

  task automatic do_op(input string name, input logic [255:0] x, input logic [255:0] y,
                       input logic [255:0] exp, input bit chk_lat);
    int nd;
    int fst;
    logic [255:0] cap;
    launch(x, y);
    watch(LAT + 2, nd, fst, cap);
    check_i({name, "_ndone"}, nd, 1);
    if (chk_lat) check_i({name, "_lat"}, fst, LAT);
    check_v({name, "_c"}, cap, exp);
  endtask

  initial begin
    int nd;
    int fst;
    logic [255:0] cap;
    logic [255:0] ra;
    logic [255:0] rb;
    logic [255:0] exp1;
    logic [255:0] exp2;

    vecs[0] = '{256'd1, 256'd1, 256'd1};
    vecs[1] = '{P256 - 256'd1, P256 - 256'd1, 256'd1};
    vecs[2] = '{256'd0, P256 - 256'd1, 256'd0};
    vecs[3] = '{ONES, 256'd1, R256M1};
    vecs[4] = '{P256, 256'd5, 256'd0};
    vecs[5] = '{256'd2, 256'd3, 256'd6};
    vecs[6] = '{256'd1 << 255, 256'd2, R256};
    vecs[7] = '{P256 - 256'd1, 256'd2, P256 - 256'd2};
    vecs[8] = '{256'd1, ONES, R256M1};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_v("reset_c", c, '0);
    check_i("reset_done", int'(done), 0);
    check_i("reset_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);

    // Starts during ITER and FIN are ignored; a start right after done is accepted.
    exp1 = ref_mul(256'h1234_5678_9abc, 256'hfedc_ba98_7654_3210);
    exp2 = 256'd35;
    launch(256'h1234_5678_9abc, 256'hfedc_ba98_7654_3210);
    nd = 0;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      if (n == 10 || n == LAT - 1 || n == LAT) begin
        start = 1'b1;
        a = 256'd7;
        b = 256'd9;
      end
      if (n == 3) check_i("ign_busy", int'(busy), 1);
      if (n == LAT) check_v("ign_c", c, exp1);
    end
    check_i("ign_ndone", nd, 1);
    @(negedge clk);
    check_i("ign_done_width", int'(done), 0);
    check_i("ign_busy_low", int'(busy), 0);
    a = 256'd5;
    b = 256'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    watch(LAT + 2, nd, fst, cap);
    check_i("b2b_ndone", nd, 1);
    check_i("b2b_lat", fst, LAT);
    check_v("b2b_c", cap, exp2);

    // Reset mid-ITER abandons the operation.
    launch(256'd11, 256'd13);
    for (int n = 1; n <= 102; n++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_v("rst_mid_c", c, '0);
    check_i("rst_mid_busy", int'(busy), 0);
    check_i("rst_mid_done", int'(done), 0);
    watch(LAT + 2, nd, fst, cap);
    check_i("rst_mid_nodone", nd, 0);
    do_op("after_rst", 256'd11, 256'd13, 256'd143, 1'b1);

    for (int k = 0; k < 250; k++) begin
      ra = rand256();
      rb = rand256();
      if (k % 5 == 0) ra = ONES - 256'($urandom_range(0, 1000));
      if (k % 7 == 0) rb = P256 + 256'($urandom_range(0, 1000));
      do_op($sformatf("rand%0d", k), ra, rb, ref_mul(ra, rb), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
